// File: rtl/Purple_Jade_pkg.sv
// Purple_Jade_pkg: shared widths, CDB broadcast type and reservation-station entry type.
package Purple_Jade_pkg;
  localparam int WIDTH_OP = 4;
  localparam int ROB_ENTRY = 16;
  localparam int NUM_PHYS_REG = 64;
  localparam int WORD_SIZE_P = 32;
  localparam int FLAG_W = 4;
  localparam int ALU_RS_ENTRIES = 4;
  localparam int ROB_W = $clog2(ROB_ENTRY);
  localparam int PREG_W = $clog2(NUM_PHYS_REG);
  typedef struct packed {
    logic valid;
    logic [PREG_W-1:0] dest;
    logic [FLAG_W-1:0] flags;
    logic [WORD_SIZE_P-1:0] result;
  } CDB_t;
  localparam int CDB_WIDTH = $bits(CDB_t);
  typedef struct packed {
    logic rdy;
    logic [PREG_W-1:0] tag;
    logic [WORD_SIZE_P-1:0] val;
  } rs_src_t;
  typedef struct packed {
    logic busy;
    logic [WIDTH_OP-1:0] opcode;
    logic w_v;
    logic [ROB_W-1:0] rob_dest;
    logic [PREG_W-1:0] reg_dest;
    rs_src_t src1;
    rs_src_t src2;
  } rs_entry_t;
  function automatic rs_src_t wake(rs_src_t s, CDB_t c);
    rs_src_t w;
    w = s;
    if (!s.rdy && c.valid && c.dest == s.tag) begin
      w.rdy = 1'b1;
      w.val = c.result;
    end
    return w;
  endfunction
endpackage

// File: rtl/alu_rs_select.sv
// rs_select: one-hot grant over issuable slots, lowest index first, or the oldest
// slot by age when ALU_RS_OLDEST_FIRST_EN is defined.
module rs_select #(
  parameter int ENTRIES = 4
) (
  input  logic [ENTRIES-1:0] req,
`ifdef ALU_RS_OLDEST_FIRST_EN
  input  logic [ENTRIES-1:0][$clog2(ENTRIES)-1:0] age,
`endif
  output logic [ENTRIES-1:0] gnt,
  output logic gnt_v
);
`ifdef ALU_RS_OLDEST_FIRST_EN
  logic [$clog2(ENTRIES)-1:0] best;
  always_comb begin
    gnt = '0;
    best = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (req[i] && (gnt == '0 || age[i] > best)) begin
        gnt = '0;
        gnt[i] = 1'b1;
        best = age[i];
      end
  end
`else
  assign gnt = req & (-req);
`endif
  assign gnt_v = |req;
endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with CDB wakeup and one registered issue per cycle.
// Define ALU_RS_OLDEST_FIRST_EN to issue the oldest ready slot instead of the lowest index.
module alu_rs
  import Purple_Jade_pkg::*;
#(
  parameter int ENTRIES = ALU_RS_ENTRIES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic flush_i,
  input  logic disp_v_i,
  output logic disp_ready_o,
  input  logic [WIDTH_OP-1:0] disp_opcode_i,
  input  logic disp_w_v_i,
  input  logic [ROB_W-1:0] disp_rob_dest_i,
  input  logic [PREG_W-1:0] disp_reg_dest_i,
  input  logic disp_src1_rdy_i,
  input  logic [PREG_W-1:0] disp_src1_tag_i,
  input  logic [WORD_SIZE_P-1:0] disp_src1_val_i,
  input  logic disp_src2_rdy_i,
  input  logic [PREG_W-1:0] disp_src2_tag_i,
  input  logic [WORD_SIZE_P-1:0] disp_src2_val_i,
  input  CDB_t cdb_i,
  output logic exe_v_o,
  output logic w_v_o,
  output logic [WIDTH_OP-1:0] opcode_o,
  output logic [WORD_SIZE_P-1:0] operand1_o,
  output logic [WORD_SIZE_P-1:0] operand2_o,
  output logic [ROB_W-1:0] rob_dest_o,
  output logic [PREG_W-1:0] reg_dest_o
);
  rs_entry_t rs_q [ENTRIES];
  rs_entry_t din;
  logic [ENTRIES-1:0] req, gnt, free, fsel;
  logic gnt_v, disp_fire;
  for (genvar g = 0; g < ENTRIES; g++) begin : g_slot
    assign req[g] = rs_q[g].busy & rs_q[g].src1.rdy & rs_q[g].src2.rdy;
    assign free[g] = ~rs_q[g].busy | gnt[g];
  end
  assign fsel = free & (-free);
  assign disp_ready_o = |free;
  assign disp_fire = disp_v_i & disp_ready_o & ~flush_i;
  // dispatch operands see the concurrent CDB so a just-produced value is not missed
  assign din = '{busy: 1'b1, opcode: disp_opcode_i, w_v: disp_w_v_i,
                 rob_dest: disp_rob_dest_i, reg_dest: disp_reg_dest_i,
                 src1: wake(rs_src_t'{disp_src1_rdy_i, disp_src1_tag_i, disp_src1_val_i}, cdb_i),
                 src2: wake(rs_src_t'{disp_src2_rdy_i, disp_src2_tag_i, disp_src2_val_i}, cdb_i)};
`ifdef ALU_RS_OLDEST_FIRST_EN
  localparam int AW = $clog2(ENTRIES);
  logic [ENTRIES-1:0][AW-1:0] age_q;
  logic [AW-1:0] gage;
  logic [ENTRIES-1:0] pass;
  always_comb begin
    gage = '0;
    for (int i = 0; i < ENTRIES; i++) if (gnt[i]) gage = age_q[i];
  end
  // a busy slot's age counts busy slots younger than it, so ages stay distinct
  for (genvar g = 0; g < ENTRIES; g++) begin : g_age
    assign pass[g] = gnt_v & (age_q[g] > gage);
  end
  always_ff @(posedge clk_i)
    if (reset_i) age_q <= '0;
    else
      for (int i = 0; i < ENTRIES; i++)
        if (disp_fire && fsel[i]) age_q[i] <= '0;
        else if (disp_fire && !pass[i]) age_q[i] <= age_q[i] + AW'(1);
        else if (!disp_fire && pass[i]) age_q[i] <= age_q[i] - AW'(1);
  rs_select #(.ENTRIES(ENTRIES)) u_sel (.req(req), .age(age_q), .gnt(gnt), .gnt_v(gnt_v));
`else
  rs_select #(.ENTRIES(ENTRIES)) u_sel (.req(req), .gnt(gnt), .gnt_v(gnt_v));
`endif
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) rs_q[i].busy <= 1'b0;
      exe_v_o <= 1'b0;
      w_v_o <= 1'b0;
      opcode_o <= '0;
      operand1_o <= '0;
      operand2_o <= '0;
      rob_dest_o <= '0;
      reg_dest_o <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) rs_q[i].busy <= 1'b0;
      exe_v_o <= 1'b0;
    end else begin
      exe_v_o <= gnt_v;
      for (int i = 0; i < ENTRIES; i++) begin
        rs_q[i].src1 <= wake(rs_q[i].src1, cdb_i);
        rs_q[i].src2 <= wake(rs_q[i].src2, cdb_i);
        if (gnt[i]) begin
          rs_q[i].busy <= 1'b0;
          w_v_o <= rs_q[i].w_v;
          opcode_o <= rs_q[i].opcode;
          operand1_o <= rs_q[i].src1.val;
          operand2_o <= rs_q[i].src2.val;
          rob_dest_o <= rs_q[i].rob_dest;
          reg_dest_o <= rs_q[i].reg_dest;
        end
        if (disp_fire && fsel[i]) rs_q[i] <= din;
      end
    end
  end
endmodule
